// File: rtl/adc_pkg.sv
// adc_pkg: definitions shared by the fast-ADC front-end blocks.
// It holds the default frame word, the aligner state encoding, the number of
// fast ADCs on the board, and a helper that sizes counters from their maximum value.
package adc_pkg;

    localparam int         NUM_FAST_ADC          = 5;
    localparam logic [7:0] FRAME_PATTERN_DEFAULT = 8'hF0;

    typedef enum logic [2:0] {
        SETTLE,
        CHECK,
        SLIP,
        LOCKED,
        FAIL
    } fa_state_t;

    // Returns the number of bits needed to hold values 0..max_value (at least 1).
    function automatic int cnt_width(input int max_value);
        return (max_value < 1) ? 1 : $clog2(max_value + 1);
    endfunction

endpackage

// File: rtl/fa_sat_cnt.sv
// fa_sat_cnt: clearable up-counter that holds at all-ones instead of wrapping.
// The frame aligner uses it for the locked-state error count and for its
// match and loss run counters.
module fa_sat_cnt
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    // Clear wins over increment; once the count reaches all-ones it stays there.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/adc_frame_align.sv
// adc_frame_align: per-ADC frame-word aligner sitting in front of the frame monitor.
// It pulses the deserializer bitslip until the registered frame word equals
// FRAME_PATTERN, declares lock after LOCK_CONFIRM consecutive matches, and
// forwards the registered word on FR_o. One instance per fast ADC.
// Optional feature: define AUTO_REALIGN_EN to drop lock and realign automatically
// after LOSS_THRESH consecutive mismatches while locked. Without it, only realign
// or rst leave the locked state and the loss run counter is not built.
module adc_frame_align
    import adc_pkg::*;
#(
    parameter logic [7:0] FRAME_PATTERN = FRAME_PATTERN_DEFAULT,
    parameter int         SLIP_WAIT     = 4,
    parameter int         LOCK_CONFIRM  = 16,
    parameter int         MAX_SLIPS     = 16,
    parameter int         LOSS_THRESH   = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  FR,
    input  logic        realign,
    output logic        bitslip,
    output logic [7:0]  FR_o,
    output logic        locked,
    output logic        fail,
    output logic [15:0] err_cnt
);

    localparam int WAIT_W  = cnt_width(SLIP_WAIT);
    localparam int MATCH_W = cnt_width(LOCK_CONFIRM);
    localparam int SLIP_W  = cnt_width(MAX_SLIPS);

    fa_state_t          state;
    fa_state_t          next_state;
    logic [7:0]         fr_q;
    logic               frame_match;
    logic [WAIT_W-1:0]  wait_cnt;
    logic [SLIP_W-1:0]  slip_cnt;
    logic [MATCH_W-1:0] match_cnt;
    logic               match_clr;
    logic               match_inc;
    logic               locked_miss;
    logic               loss_hit;

    // Every decision is made on the registered word, so FR_o and the compare see the same value.
    assign frame_match = (fr_q == FRAME_PATTERN);
    assign FR_o        = fr_q;

    // The outputs are decoded straight from the state register, so they are glitch-free
    // and a bitslip already in progress completes even if realign arrives in that cycle.
    assign bitslip = (state == SLIP);
    assign locked  = (state == LOCKED);
    assign fail    = (state == FAIL);

    // The match run only grows while comparing; leaving CHECK or a realign restarts it.
    assign match_clr   = realign || (state != CHECK);
    assign match_inc   = (state == CHECK) && frame_match;
    assign locked_miss = (state == LOCKED) && !frame_match;

    fa_sat_cnt #(
        .WIDTH (MATCH_W)
    ) u_match_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (match_clr),
        .inc   (match_inc),
        .count (match_cnt)
    );

    // The error count survives realign on purpose so the monitor can see link history;
    // only rst clears it.
    fa_sat_cnt #(
        .WIDTH (16)
    ) u_err_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (1'b0),
        .inc   (locked_miss),
        .count (err_cnt)
    );

`ifdef AUTO_REALIGN_EN
    localparam int LOSS_W = cnt_width(LOSS_THRESH);

    logic [LOSS_W-1:0] loss_cnt;
    logic              loss_clr;

    // Any match, leaving LOCKED, or a realign breaks the run of consecutive mismatches.
    assign loss_clr = realign || !locked_miss;
    assign loss_hit = locked_miss && (loss_cnt == LOSS_W'(LOSS_THRESH - 1));

    fa_sat_cnt #(
        .WIDTH (LOSS_W)
    ) u_loss_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (loss_clr),
        .inc   (locked_miss),
        .count (loss_cnt)
    );
`else
    assign loss_hit = 1'b0;
`endif

    // State register plus the input word register that all compares use.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= SETTLE;
            fr_q  <= '0;
        end else begin
            state <= next_state;
            fr_q  <= FR;
        end
    end

    // Settle timer restarts on every entry to SETTLE; the slip budget restarts on realign or loss.
    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt <= '0;
            slip_cnt <= '0;
        end else begin
            if ((state == SETTLE) && (next_state == SETTLE) && !realign) begin
                wait_cnt <= wait_cnt + WAIT_W'(1);
            end else begin
                wait_cnt <= '0;
            end

            if (realign || loss_hit) begin
                slip_cnt <= '0;
            end else if (state == SLIP) begin
                slip_cnt <= slip_cnt + SLIP_W'(1);
            end
        end
    end

    // Next-state logic. SETTLE lasts SLIP_WAIT+1 cycles so the compare never sees a word
    // that was still in the input register when the deserializer slipped. realign overrides all.
    always_comb begin
        next_state = state;
        case (state)
            SETTLE: begin
                if (wait_cnt == WAIT_W'(SLIP_WAIT)) begin
                    next_state = CHECK;
                end
            end
            CHECK: begin
                if (frame_match) begin
                    if (match_cnt == MATCH_W'(LOCK_CONFIRM - 1)) begin
                        next_state = LOCKED;
                    end
                end else if (slip_cnt == SLIP_W'(MAX_SLIPS)) begin
                    next_state = FAIL;
                end else begin
                    next_state = SLIP;
                end
            end
            SLIP: begin
                next_state = SETTLE;
            end
            LOCKED: begin
                if (loss_hit) begin
                    next_state = SETTLE;
                end
            end
            FAIL: begin
                next_state = FAIL;
            end
            default: begin
                next_state = SETTLE;
            end
        endcase
        if (realign) begin
            next_state = SETTLE;
        end
    end

endmodule

// File: tb/tb_adc_frame_align.sv
// tb_adc_frame_align: directed bench for adc_frame_align with a behavioural reference
// model that is compared against the DUT outputs on every cycle, plus hand-computed
// expectations for lock latency, slip counts, error counts and realign timing.
// Build with AUTO_REALIGN_EN defined to exercise the automatic loss/realign path.
module tb_adc_frame_align;

    localparam logic [7:0] PAT          = 8'hF0;
    localparam int         SLIP_WAIT    = 4;
    localparam int         LOCK_CONFIRM = 16;
    localparam int         MAX_SLIPS    = 16;
    localparam int         LOSS_THRESH  = 8;

    logic        clk     = 1'b0;
    logic        rst     = 1'b1;
    logic        realign = 1'b0;
    logic [7:0]  FR      = 8'h00;
    logic        bitslip;
    logic [7:0]  FR_o;
    logic        locked;
    logic        fail;
    logic [15:0] err_cnt;

    int vectors     = 0;
    int miscompares = 0;
    int cycle       = 0;
    int slipPulses  = 0;
    int lastSlip    = -1;
    bit checkEn     = 1'b0;

    // Reference model: what the outputs must be after each edge, from the behavioural rules.
    logic [7:0]  mFrq;
    logic [7:0]  mPrev;
    logic        mSlipNow;
    logic        mLocked;
    logic        mFailed;
    logic [15:0] mErr;
    int          mSettleLeft;
    int          mRun;
    int          mSlips;
    int          mLoss;

    adc_frame_align dut (
        .clk     (clk),
        .rst     (rst),
        .FR      (FR),
        .realign (realign),
        .bitslip (bitslip),
        .FR_o    (FR_o),
        .locked  (locked),
        .fail    (fail),
        .err_cnt (err_cnt)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cycle);
        end
    endtask

    // Model update: the word is registered, a settle window follows every slip or restart,
    // matches build a run, a broken run costs a slip, and the slip budget ends in failure.
    always @(posedge clk) begin
        if (rst) begin
            cycle       = 0;
            mFrq        = 8'h00;
            mSlipNow    = 1'b0;
            mLocked     = 1'b0;
            mFailed     = 1'b0;
            mErr        = 16'h0000;
            mSettleLeft = SLIP_WAIT + 1;
            mRun        = 0;
            mSlips      = 0;
            mLoss       = 0;
        end else begin
            cycle++;
            mPrev = mFrq;
            mFrq  = FR;
            if (mLocked && (mPrev != PAT) && (mErr != 16'hFFFF)) begin
                mErr = mErr + 16'd1;
            end
            if (realign) begin
                mSlipNow    = 1'b0;
                mLocked     = 1'b0;
                mFailed     = 1'b0;
                mSlips      = 0;
                mRun        = 0;
                mLoss       = 0;
                mSettleLeft = SLIP_WAIT + 1;
            end else if (mSlipNow) begin
                mSlipNow    = 1'b0;
                mSettleLeft = SLIP_WAIT + 1;
            end else if (mSettleLeft > 0) begin
                mSettleLeft--;
            end else if (mFailed) begin
                mFailed = 1'b1;
            end else if (mLocked) begin
`ifdef AUTO_REALIGN_EN
                if (mPrev != PAT) begin
                    mLoss++;
                    if (mLoss == LOSS_THRESH) begin
                        mLocked     = 1'b0;
                        mSlips      = 0;
                        mLoss       = 0;
                        mRun        = 0;
                        mSettleLeft = SLIP_WAIT + 1;
                    end
                end else begin
                    mLoss = 0;
                end
`endif
            end else if (mPrev == PAT) begin
                mRun++;
                if (mRun == LOCK_CONFIRM) begin
                    mLocked = 1'b1;
                    mRun    = 0;
                end
            end else begin
                mRun = 0;
                if (mSlips == MAX_SLIPS) begin
                    mFailed = 1'b1;
                end else begin
                    mSlips++;
                    mSlipNow = 1'b1;
                end
            end
        end
    end

    // Compare process: every cycle, away from the active edge, DUT against model,
    // plus the minimum spacing rule between bitslip pulses.
    always @(negedge clk) begin
        if (rst) begin
            lastSlip = -1;
        end
        if (checkEn) begin
            checkOutput("bitslip", {31'b0, bitslip}, {31'b0, mSlipNow});
            checkOutput("locked", {31'b0, locked}, {31'b0, mLocked});
            checkOutput("fail", {31'b0, fail}, {31'b0, mFailed});
            checkOutput("FR_o", {24'b0, FR_o}, {24'b0, mFrq});
            checkOutput("err_cnt", {16'b0, err_cnt}, {16'b0, mErr});
            if (bitslip === 1'b1) begin
                if (lastSlip >= 0) begin
                    checkOutput("slip_spacing", {31'b0, ((cycle - lastSlip) >= SLIP_WAIT + 1)}, 32'd1);
                end
                lastSlip = cycle;
                slipPulses++;
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Drive one cycle of inputs, then return once the resulting outputs are settled.
    task automatic applyStimulus(input logic ra, input logic [7:0] fr);
        realign = ra;
        FR      = fr;
        tick();
    endtask

    task automatic doReset(input logic [7:0] fr);
        rst     = 1'b1;
        realign = 1'b0;
        FR      = fr;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        #5000000;
        $display("[TB] FAIL watchdog: time limit reached, vectors=%0d", vectors);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n;
        int base;
        logic [7:0] chan;
        logic [7:0] glitch [3];
        glitch[0] = 8'hA5;
        glitch[1] = 8'h00;
        glitch[2] = 8'h0F;

        // Test 1: correct word from reset, lock without any bitslip.
        doReset(PAT);
        checkEn = 1'b1;
        checkOutput("reset_locked", {31'b0, locked}, 32'd0);
        checkOutput("reset_err", {16'b0, err_cnt}, 32'd0);
        base = slipPulses;
        n = 0;
        while (locked !== 1'b1 && n < 60) begin
            applyStimulus(1'b0, PAT);
            n++;
        end
        checkOutput("t1_lock_cycle", cycle, 32'd21);
        checkOutput("t1_no_slips", slipPulses - base, 32'd0);

        // Test 4: three single-cycle glitches while locked.
        for (int g = 0; g < 3; g++) begin
            applyStimulus(1'b0, glitch[g]);
            checkOutput("t4_fr_o_follows", {24'b0, FR_o}, {24'b0, glitch[g]});
            applyStimulus(1'b0, PAT);
        end
        applyStimulus(1'b0, PAT);
        checkOutput("t4_err_three", {16'b0, err_cnt}, 32'd3);
        checkOutput("t4_still_locked", {31'b0, locked}, 32'd1);
`ifndef AUTO_REALIGN_EN
        for (int i = 0; i < 70000; i++) begin
            applyStimulus(1'b0, 8'h00);
        end
        checkOutput("t4_err_saturated", {16'b0, err_cnt}, 32'h0000FFFF);
        checkOutput("t4_locked_after_sat", {31'b0, locked}, 32'd1);
`endif

        // Reset mid-operation clears everything, including the error count.
        doReset(8'h1E);
        checkOutput("rst_err_cleared", {16'b0, err_cnt}, 32'd0);
        checkOutput("rst_unlocked", {31'b0, locked}, 32'd0);

        // Test 2: word starts three slips away from the pattern; the bench emulates
        // the deserializer by rotating the word on each bitslip pulse.
        chan = 8'h1E;
        base = slipPulses;
        n = 0;
        while (locked !== 1'b1 && n < 300) begin
            if (bitslip === 1'b1) begin
                chan = {chan[6:0], chan[7]};
            end
            applyStimulus(1'b0, chan);
            n++;
        end
        checkOutput("t2_slip_count", slipPulses - base, 32'd3);
        checkOutput("t2_locked", {31'b0, locked}, 32'd1);
        checkOutput("t2_word", {24'b0, FR_o}, {24'b0, PAT});

        // Test 3: a dead word exhausts the slip budget and the block gives up.
        doReset(8'h00);
        base = slipPulses;
        n = 0;
        while (fail !== 1'b1 && n < 400) begin
            applyStimulus(1'b0, 8'h00);
            n++;
        end
        checkOutput("t3_slip_count", slipPulses - base, 32'd16);
        checkOutput("t3_fail", {31'b0, fail}, 32'd1);
        for (int i = 0; i < 40; i++) begin
            applyStimulus(1'b0, 8'h00);
        end
        checkOutput("t3_no_more_slips", slipPulses - base, 32'd16);
        applyStimulus(1'b1, 8'h00);
        checkOutput("t3_fail_cleared", {31'b0, fail}, 32'd0);
        n = 0;
        while (bitslip !== 1'b1 && n < 50) begin
            applyStimulus(1'b0, 8'h00);
            n++;
        end
        checkOutput("t3_restart_gap", n, 32'd6);

        // Test 6: realign in the same cycle as a compare mismatch, after some slips.
        doReset(8'h00);
        base = slipPulses;
        n = 0;
        while ((slipPulses - base) < 3 && n < 100) begin
            applyStimulus(1'b0, 8'h00);
            n++;
        end
        n = 0;
        while (!(mSettleLeft == 0 && !mSlipNow && !mLocked && !mFailed) && n < 20) begin
            applyStimulus(1'b0, 8'h00);
            n++;
        end
        applyStimulus(1'b1, 8'h00);
        checkOutput("t6_no_pulse", {31'b0, bitslip}, 32'd0);
        checkOutput("t6_not_failed", {31'b0, fail}, 32'd0);
        base = slipPulses;
        n = 0;
        while (bitslip !== 1'b1 && n < 50) begin
            applyStimulus(1'b0, 8'h00);
            n++;
        end
        checkOutput("t6_resume_gap", n, 32'd6);
        n = 0;
        while (fail !== 1'b1 && n < 400) begin
            applyStimulus(1'b0, 8'h00);
            n++;
        end
        checkOutput("t6_full_budget", slipPulses - base, 32'd16);

`ifdef AUTO_REALIGN_EN
        // Test 5: seven mismatches keep lock, eight drop it and realignment re-locks.
        doReset(PAT);
        n = 0;
        while (locked !== 1'b1 && n < 60) begin
            applyStimulus(1'b0, PAT);
            n++;
        end
        for (int i = 0; i < 7; i++) begin
            applyStimulus(1'b0, 8'h00);
        end
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, PAT);
        end
        checkOutput("t5_hold", {31'b0, locked}, 32'd1);
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b0, 8'h00);
        end
        applyStimulus(1'b0, PAT);
        checkOutput("t5_unlock", {31'b0, locked}, 32'd0);
        n = 0;
        while (locked !== 1'b1 && n < 100) begin
            applyStimulus(1'b0, PAT);
            n++;
        end
        checkOutput("t5_relock", {31'b0, locked}, 32'd1);
`endif

        checkEn = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
